// File: rtl/jesd204_tx_scrambler_ctrl_pkg.sv
// jesd204_tx_scrambler_ctrl_pkg: link-phase state encoding and register-map status codes
package jesd204_tx_scrambler_ctrl_pkg;
  typedef enum logic [2:0] {ST_DISABLED, ST_CGS, ST_WAIT_LMFC, ST_ILAS, ST_DATA} state_e;
  localparam logic [1:0] STATUS_CGS = 2'd0;
  localparam logic [1:0] STATUS_WAIT_LMFC = 2'd1;
  localparam logic [1:0] STATUS_ILAS = 2'd2;
  localparam logic [1:0] STATUS_DATA = 2'd3;
  function automatic logic [1:0] status_of(state_e s);
    return s == ST_WAIT_LMFC ? STATUS_WAIT_LMFC : s == ST_ILAS ? STATUS_ILAS :
           s == ST_DATA ? STATUS_DATA : STATUS_CGS;
  endfunction
endpackage

// File: rtl/jesd204_tx_scrambler_ctrl_if.sv
// jesd204_tx_scrambler_ctrl_if: link control inputs and per-lane scrambler controls
interface jesd204_tx_scrambler_ctrl_if #(
  parameter int NUM_LANES = 1,
  parameter int MFRAME_CNT_W = 8,
  parameter int RESYNC_CNT_W = 4
);
  logic cfg_scrambler_disable;
  logic [MFRAME_CNT_W-1:0] cfg_ilas_mframes;
  logic [RESYNC_CNT_W-1:0] cfg_resync_threshold;
  logic link_enable;
  logic sync_n;
  logic lmfc_edge;
  logic [NUM_LANES-1:0] scr_reset;
  logic [NUM_LANES-1:0] scr_enable;
  logic ilas_active;
  logic [MFRAME_CNT_W-1:0] ilas_mframe_cnt;
  logic [1:0] status_state;
  logic [7:0] status_resync_count;
  logic event_sync_glitch;
  modport master (
    output cfg_scrambler_disable, cfg_ilas_mframes, cfg_resync_threshold, link_enable, sync_n, lmfc_edge,
    input scr_reset, scr_enable, ilas_active, ilas_mframe_cnt, status_state, status_resync_count, event_sync_glitch
  );
  modport slave (
    input cfg_scrambler_disable, cfg_ilas_mframes, cfg_resync_threshold, link_enable, sync_n, lmfc_edge,
    output scr_reset, scr_enable, ilas_active, ilas_mframe_cnt, status_state, status_resync_count, event_sync_glitch
  );
endinterface

// File: rtl/jesd204_tx_scrambler_ctrl_sync_filter.sv
// jesd204_tx_scrambler_ctrl_sync_filter: sync_n low-run counter flagging resync and short glitches
module jesd204_tx_scrambler_ctrl_sync_filter #(
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic active_i,
  input  logic sync_n_i,
  input  logic [CNT_W-1:0] threshold_i,
  output logic resync_o,
  output logic glitch_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d, thr, cnt_inc;
  always_comb begin
    thr = threshold_i == '0 ? CNT_W'(1) : threshold_i;
    cnt_inc = cnt_q + 1'b1;
    resync_o = active_i && !sync_n_i && cnt_inc == thr;
    glitch_o = active_i && sync_n_i && cnt_q != '0;
    cnt_d = (!active_i || sync_n_i || resync_o) ? '0 : cnt_inc;
  end
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/jesd204_tx_scrambler_ctrl.sv
// jesd204_tx_scrambler_ctrl: CGS/WAIT_LMFC/ILAS/DATA sequencer driving lane scrambler reset and enable
module jesd204_tx_scrambler_ctrl import jesd204_tx_scrambler_ctrl_pkg::*; #(
  parameter int NUM_LANES = 1,
  parameter int MFRAME_CNT_W = 8,
  parameter int RESYNC_CNT_W = 4
) (
  input logic clk,
  input logic reset,
  jesd204_tx_scrambler_ctrl_if.slave bus
);
  state_e state_q, state_d;
  logic [MFRAME_CNT_W-1:0] mf_q, mf_d;
  logic [7:0] rcnt_q, rcnt_d;
  logic [NUM_LANES-1:0] scr_reset_q, scr_reset_d, scr_enable_q, scr_enable_d;
  logic [1:0] status_q, status_d;
  logic ilas_q, ilas_d, event_q, event_d;
  logic resync, glitch, filt_active, last_mf;
  assign filt_active = state_q inside {ST_WAIT_LMFC, ST_ILAS, ST_DATA};
  assign last_mf = mf_q == bus.cfg_ilas_mframes - 1'b1;
  jesd204_tx_scrambler_ctrl_sync_filter #(.CNT_W(RESYNC_CNT_W)) u_filter (
    .clk(clk),
    .reset(reset),
    .active_i(filt_active),
    .sync_n_i(bus.sync_n),
    .threshold_i(bus.cfg_resync_threshold),
    .resync_o(resync),
    .glitch_o(glitch)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_DISABLED;
      mf_q <= '0;
      rcnt_q <= '0;
      scr_reset_q <= '1;
      scr_enable_q <= '0;
      status_q <= STATUS_CGS;
      ilas_q <= 1'b0;
      event_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mf_q <= mf_d;
      rcnt_q <= rcnt_d;
      scr_reset_q <= scr_reset_d;
      scr_enable_q <= scr_enable_d;
      status_q <= status_d;
      ilas_q <= ilas_d;
      event_q <= event_d;
    end
  end
  // disable beats everything, then resync beats any lmfc_edge progression
  always_comb begin
    state_d = !bus.link_enable ? ST_DISABLED :
              state_q == ST_DISABLED ? ST_CGS :
              state_q == ST_CGS ? (bus.sync_n ? ST_WAIT_LMFC : ST_CGS) :
              resync ? ST_CGS :
              (bus.lmfc_edge && state_q == ST_WAIT_LMFC) ? ST_ILAS :
              (bus.lmfc_edge && state_q == ST_ILAS && last_mf) ? ST_DATA : state_q;
  end
  // outputs decode the next state so they line up with the beat the state applies to
  always_comb begin
    mf_d = state_d != ST_ILAS ? '0 : (state_q == ST_ILAS && bus.lmfc_edge) ? mf_q + 1'b1 : mf_q;
    rcnt_d = (state_q == ST_DATA && state_d == ST_CGS && rcnt_q != 8'hff) ? rcnt_q + 1'b1 : rcnt_q;
    scr_reset_d = state_d == ST_DATA ? '0 : '1;
    scr_enable_d = state_d == ST_DATA ? {NUM_LANES{~bus.cfg_scrambler_disable}} : '0;
    status_d = status_of(state_d);
    ilas_d = state_d == ST_ILAS;
    event_d = glitch && state_q == ST_DATA && state_d == ST_DATA;
  end
  assign bus.scr_reset = scr_reset_q;
  assign bus.scr_enable = scr_enable_q;
  assign bus.ilas_active = ilas_q;
  assign bus.ilas_mframe_cnt = mf_q;
  assign bus.status_state = status_q;
  assign bus.status_resync_count = rcnt_q;
  assign bus.event_sync_glitch = event_q;
endmodule

// File: tb/tb_jesd204_tx_scrambler_ctrl.sv
// tb_jesd204_tx_scrambler_ctrl: directed vector table plus multi-cycle link-phase sequences
module tb_jesd204_tx_scrambler_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  jesd204_tx_scrambler_ctrl_if #(.NUM_LANES(2)) bus ();
  jesd204_tx_scrambler_ctrl #(.NUM_LANES(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  int n_vec = 0;
  int n_err = 0;
  typedef struct {
    logic le, sn, lmfc;
    logic [1:0] st;
    logic il;
    logic [7:0] mf;
    logic [7:0] rc;
    logic ev;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t v(logic le, logic sn, logic lmfc, logic [1:0] st, logic il,
                             logic [7:0] mf, logic [7:0] rc, logic ev);
    vec_t r;
    r.le = le; r.sn = sn; r.lmfc = lmfc; r.st = st; r.il = il; r.mf = mf; r.rc = rc; r.ev = ev;
    return r;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle(input string tag, input logic [7:0] rc);
    check({tag, "_state"}, bus.status_state, 0);
    check({tag, "_scr_reset"}, bus.scr_reset, 2'b11);
    check({tag, "_scr_enable"}, bus.scr_enable, 0);
    check({tag, "_ilas"}, bus.ilas_active, 0);
    check({tag, "_mf"}, bus.ilas_mframe_cnt, 0);
    check({tag, "_event"}, bus.event_sync_glitch, 0);
    check({tag, "_rc"}, bus.status_resync_count, rc);
  endtask
  task automatic run_bringup(input logic dis);
    int ilas_n = 0;
    int mf_bad = 0;
    logic seen = 1'b0;
    logic [1:0] prev_rst = 2'b00;
    bus.link_enable = 1; bus.sync_n = 0; bus.lmfc_edge = 0;
    step(); step();
    check("bringup_cgs", bus.status_state, 0);
    bus.sync_n = 1;
    for (int c = 0; c < 400 && !seen; c++) begin
      bus.lmfc_edge = (c % 32 == 20);
      prev_rst = bus.scr_reset;
      step();
      if (bus.ilas_active) begin
        if (bus.ilas_mframe_cnt !== 8'(ilas_n / 32)) mf_bad++;
        ilas_n++;
      end
      seen = bus.status_state == 2'd3;
    end
    bus.lmfc_edge = 0;
    check("bringup_data_reached", seen, 1);
    check("bringup_ilas_len", ilas_n, 128);
    check("bringup_mf_steps", mf_bad, 0);
    check("bringup_last_ilas_scr_reset", prev_rst, 2'b11);
    check("bringup_data_scr_reset", bus.scr_reset, 0);
    check("bringup_data_scr_enable", bus.scr_enable, dis ? 2'b00 : 2'b11);
    check("bringup_data_ilas", bus.ilas_active, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int ev_n;
    int sat_bad;
    tbl.push_back(v(1,0,0, 0,0,0,0,0));
    tbl.push_back(v(1,0,0, 0,0,0,0,0));
    tbl.push_back(v(1,1,0, 1,0,0,0,0));
    tbl.push_back(v(1,1,1, 2,1,0,0,0));
    tbl.push_back(v(1,1,0, 2,1,0,0,0));
    tbl.push_back(v(1,1,1, 2,1,1,0,0));
    tbl.push_back(v(1,0,0, 2,1,1,0,0));
    tbl.push_back(v(1,1,0, 2,1,1,0,0));
    tbl.push_back(v(1,1,1, 3,0,0,0,0));
    tbl.push_back(v(1,0,0, 3,0,0,0,0));
    tbl.push_back(v(1,1,0, 3,0,0,0,1));
    tbl.push_back(v(1,1,0, 3,0,0,0,0));
    tbl.push_back(v(1,0,0, 3,0,0,0,0));
    tbl.push_back(v(1,0,0, 0,0,0,1,0));
    tbl.push_back(v(1,1,0, 1,0,0,1,0));
    tbl.push_back(v(1,1,1, 2,1,0,1,0));
    tbl.push_back(v(1,0,1, 2,1,1,1,0));
    tbl.push_back(v(1,0,1, 0,0,0,1,0));
    tbl.push_back(v(1,1,0, 1,0,0,1,0));
    tbl.push_back(v(1,1,1, 2,1,0,1,0));
    tbl.push_back(v(1,1,1, 2,1,1,1,0));
    tbl.push_back(v(0,1,1, 0,0,0,1,0));
    tbl.push_back(v(1,1,0, 0,0,0,1,0));
    tbl.push_back(v(1,1,0, 1,0,0,1,0));
    tbl.push_back(v(1,1,1, 2,1,0,1,0));
    tbl.push_back(v(1,1,1, 2,1,1,1,0));
    tbl.push_back(v(1,1,1, 3,0,0,1,0));
    tbl.push_back(v(0,0,0, 0,0,0,1,0));
    reset = 1;
    bus.link_enable = 0; bus.sync_n = 0; bus.lmfc_edge = 0;
    bus.cfg_scrambler_disable = 0; bus.cfg_ilas_mframes = 2; bus.cfg_resync_threshold = 2;
    step(); step();
    check_idle("reset", 0);
    reset = 0;
    foreach (tbl[i]) begin
      bus.link_enable = tbl[i].le; bus.sync_n = tbl[i].sn; bus.lmfc_edge = tbl[i].lmfc;
      step();
      check($sformatf("vec%0d_state", i), bus.status_state, tbl[i].st);
      check($sformatf("vec%0d_ilas", i), bus.ilas_active, tbl[i].il);
      check($sformatf("vec%0d_mf", i), bus.ilas_mframe_cnt, tbl[i].mf);
      check($sformatf("vec%0d_scr_reset", i), bus.scr_reset, tbl[i].st == 3 ? 2'b00 : 2'b11);
      check($sformatf("vec%0d_scr_enable", i), bus.scr_enable, tbl[i].st == 3 ? 2'b11 : 2'b00);
      check($sformatf("vec%0d_rc", i), bus.status_resync_count, tbl[i].rc);
      check($sformatf("vec%0d_event", i), bus.event_sync_glitch, tbl[i].ev);
    end
    bus.link_enable = 0; bus.lmfc_edge = 0;
    step();
    check("disable_keeps_rc", bus.status_resync_count, 1);
    bus.cfg_ilas_mframes = 4; bus.cfg_resync_threshold = 5;
    reset = 1; step(); reset = 0;
    check("reset_clears_rc", bus.status_resync_count, 0);
    run_bringup(0);
    bus.sync_n = 0;
    repeat (4) step();
    check("short_low_state", bus.status_state, 3);
    bus.sync_n = 1;
    ev_n = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      ev_n += int'(bus.event_sync_glitch);
    end
    check("glitch_pulses", ev_n, 1);
    check("glitch_state", bus.status_state, 3);
    bus.sync_n = 0;
    repeat (4) step();
    check("long_low_pre_state", bus.status_state, 3);
    step();
    check("resync_state", bus.status_state, 0);
    check("resync_rc", bus.status_resync_count, 1);
    check("resync_scr_reset", bus.scr_reset, 2'b11);
    check("resync_scr_enable", bus.scr_enable, 0);
    run_bringup(0);
    reset = 1;
    step();
    check_idle("midrun_reset", 0);
    reset = 0;
    run_bringup(0);
    bus.link_enable = 0;
    step();
    bus.cfg_scrambler_disable = 1;
    run_bringup(1);
    bus.link_enable = 0;
    step();
    bus.cfg_scrambler_disable = 0; bus.cfg_ilas_mframes = 1; bus.cfg_resync_threshold = 0;
    reset = 1; step(); reset = 0;
    bus.link_enable = 1; bus.sync_n = 0;
    step();
    sat_bad = 0;
    for (int i = 0; i < 300; i++) begin
      bus.sync_n = 1; step();
      bus.lmfc_edge = 1; step(); step();
      if (bus.status_state !== 2'd3) sat_bad++;
      bus.lmfc_edge = 0; bus.sync_n = 0; step();
      if (bus.status_state !== 2'd0 || bus.status_resync_count !== 8'(i < 255 ? i + 1 : 255)) sat_bad++;
    end
    check("sat_iteration_errors", sat_bad, 0);
    check("sat_count", bus.status_resync_count, 255);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
